// File: rtl/seq_divider_16x8_pkg.sv
// ---------------------------------------------------------------------------
// seq_divider_16x8_pkg
// Shared arithmetic definitions for the sequential restoring divider:
//   DIV_WIDTH   - default divisor/remainder width (dividend/quotient are 2x)
//   div_state_t - controller states
//   cnt_width() - step-counter width able to hold 0..2*W
// ---------------------------------------------------------------------------
package seq_divider_16x8_pkg;

  localparam int DIV_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  function automatic int cnt_width(input int w);
    return $clog2(2 * w + 1);
  endfunction

  localparam int CNT_W = cnt_width(DIV_WIDTH);

endpackage

// File: rtl/seq_divider_16x8_if.sv
// ---------------------------------------------------------------------------
// seq_divider_16x8_if
// Start/done handshake bundle between a requester (master) and the divider
// (slave).
//   start, dividend, divisor              : master -> divider
//   busy, done, quotient, remainder,
//   div_by_zero                           : divider -> master
// ---------------------------------------------------------------------------
interface seq_divider_16x8_if
  import seq_divider_16x8_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) ();

  logic                 start;
  logic [2*WIDTH-1:0]   dividend;
  logic [WIDTH-1:0]     divisor;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   quotient;
  logic [WIDTH-1:0]     remainder;
  logic                 div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/seq_divider_16x8_restoring_div_step.sv
// ---------------------------------------------------------------------------
// restoring_div_step
// One combinational restoring-division step: shift the next dividend bit into
// the partial remainder, trial-subtract the divisor, and keep the difference
// only when it did not borrow.
//   r_i     : partial remainder (W+1 bits)
//   q_bit_i : incoming dividend bit (MSB of the quotient shift register)
//   d_i     : divisor
//   r_o     : next partial remainder
//   q_o     : resulting quotient bit (1 = subtraction kept)
// ---------------------------------------------------------------------------
module restoring_div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   r_i,
  input  logic             q_bit_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH:0]   r_o,
  output logic             q_o
);

  logic [WIDTH:0]   r_sh;
  logic [WIDTH+1:0] diff;
  logic             borrow;

  always_comb begin
    r_sh   = {r_i[WIDTH-1:0], q_bit_i};
    // One extra bit on top of the (W+1)-bit subtract carries the borrow out.
    diff   = {1'b0, r_sh} - {2'b00, d_i};
    borrow = diff[WIDTH+1];
    r_o    = borrow ? r_sh : diff[WIDTH:0];
    q_o    = ~borrow;
  end

endmodule

// File: rtl/seq_divider_16x8.sv
// ---------------------------------------------------------------------------
// seq_divider_16x8
// Iterative restoring divider: 2W-bit dividend / W-bit divisor, one quotient
// bit per clock, 2W steps per operation. Divide-by-zero completes at once with
// quotient all ones and remainder = low half of the dividend.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : handshake/data bundle (slave side), see seq_divider_16x8_if
//
//   state | meaning
//   IDLE  | waiting for start
//   CALC  | shifting/subtracting, one quotient bit per edge
//   DONE  | one-cycle result strobe; a new start may be accepted here
// ---------------------------------------------------------------------------
module seq_divider_16x8
  import seq_divider_16x8_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  seq_divider_16x8_if.slave    bus
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(2 * WIDTH - 1);

  div_state_t           state_q;
  logic [WIDTH:0]       r_q;
  logic [2*WIDTH-1:0]   q_q;
  logic [WIDTH-1:0]     d_q;
  logic [CW-1:0]        cnt_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 dbz_q;
  logic [2*WIDTH-1:0]   quot_q;
  logic [WIDTH-1:0]     rem_q;

  logic [WIDTH:0]       r_d;
  logic                 q_bit_d;
  logic [2*WIDTH-1:0]   q_d;

  restoring_div_step #(.WIDTH(WIDTH)) u_step (
    .r_i     (r_q),
    .q_bit_i (q_q[2*WIDTH-1]),
    .d_i     (d_q),
    .r_o     (r_d),
    .q_o     (q_bit_d)
  );

  // The dividend shifts out of the top while quotient bits shift in below.
  assign q_d = {q_q[2*WIDTH-2:0], q_bit_d};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          state_q <= IDLE;
          if (bus.start) begin
            dbz_q <= 1'b0;
            q_q   <= bus.dividend;
            d_q   <= bus.divisor;
            r_q   <= '0;
            cnt_q <= '0;
            if (bus.divisor == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              dbz_q   <= 1'b1;
              quot_q  <= '1;
              rem_q   <= bus.dividend[WIDTH-1:0];
            end else begin
              state_q <= CALC;
              busy_q  <= 1'b1;
            end
          end
        end
        CALC: begin
          r_q   <= r_d;
          q_q   <= q_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_STEP) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            quot_q  <= q_d;
            rem_q   <= r_d[WIDTH-1:0];
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quot_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider_16x8.sv
// ---------------------------------------------------------------------------
// tb_seq_divider_16x8
// Self-checking bench for seq_divider_16x8 (W=8). Expected results come from
// plain integer division in the bench; latency and busy/done behaviour from
// the documented handshake timing.
// ---------------------------------------------------------------------------
module tb_seq_divider_16x8;

  logic clk;
  logic rst;

  int n_checks;
  int n_fail;

  seq_divider_16x8_if #(.WIDTH(8)) bus_if ();

  seq_divider_16x8 #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
               tag, obs, obs, exp, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: integer division, with the divide-by-zero convention.
  function automatic logic [15:0] ref_quot(input logic [15:0] a, input logic [7:0] b);
    return (b == 8'd0) ? 16'hFFFF : a / {8'd0, b};
  endfunction

  function automatic logic [7:0] ref_rem(input logic [15:0] a, input logic [7:0] b);
    logic [15:0] r;
    r = (b == 8'd0) ? a : a % {8'd0, b};
    return r[7:0];
  endfunction

  // Issues one operation (start seen at the next edge E0) and waits for done.
  // Returns in the done cycle so the caller may chain a back-to-back start.
  task automatic do_div(input string tag, input logic [15:0] a, input logic [7:0] b,
                        input bit check_inv);
    int lat;
    int busy_cnt;
    logic [15:0] q;
    logic [7:0]  r;
    bus_if.start    = 1'b1;
    bus_if.dividend = a;
    bus_if.divisor  = b;
    tick();
    bus_if.start    = 1'b0;
    // Operands are captured at E0; later changes must not matter.
    bus_if.dividend = 16'($urandom);
    bus_if.divisor  = 8'($urandom);
    lat = 0;
    busy_cnt = 0;
    while (!bus_if.done && lat < 40) begin
      busy_cnt += int'(bus_if.busy);
      tick();
      lat++;
    end
    chk({tag, "_latency"}, lat, (b == 8'd0) ? 0 : 16);
    chk({tag, "_busy_cycles"}, busy_cnt, (b == 8'd0) ? 0 : 16);
    chk({tag, "_busy_at_done"}, bus_if.busy, 0);
    chk({tag, "_quot"}, bus_if.quotient, ref_quot(a, b));
    chk({tag, "_rem"}, bus_if.remainder, ref_rem(a, b));
    chk({tag, "_dbz"}, bus_if.div_by_zero, (b == 8'd0) ? 1 : 0);
    if (check_inv && b != 8'd0) begin
      q = bus_if.quotient;
      r = bus_if.remainder;
      chk({tag, "_invariant"}, 32'(q) * 32'(b) + 32'(r), 32'(a));
      chk({tag, "_rem_lt_div"}, (r < b) ? 1 : 0, 1);
    end
  endtask

  // Confirms done was a single-cycle pulse and the results are held.
  task automatic check_idle_after(input string tag, input logic [15:0] a, input logic [7:0] b);
    tick();
    chk({tag, "_done_pulse"}, bus_if.done, 0);
    chk({tag, "_quot_held"}, bus_if.quotient, ref_quot(a, b));
    chk({tag, "_rem_held"}, bus_if.remainder, ref_rem(a, b));
    chk({tag, "_busy_idle"}, bus_if.busy, 0);
  endtask

  initial begin
    int lat;
    int extra_done;
    logic [15:0] a;
    logic [7:0]  b;

    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    bus_if.start    = 1'b0;
    bus_if.dividend = '0;
    bus_if.divisor  = '0;
    repeat (3) tick();
    chk("rst_busy", bus_if.busy, 0);
    chk("rst_done", bus_if.done, 0);
    chk("rst_quot", bus_if.quotient, 0);
    chk("rst_rem", bus_if.remainder, 0);
    chk("rst_dbz", bus_if.div_by_zero, 0);
    rst = 1'b0;
    tick();

    // Directed cases
    do_div("d1000_7", 16'd1000, 8'd7, 1'b1);
    check_idle_after("d1000_7", 16'd1000, 8'd7);
    do_div("dFFFF_FF", 16'hFFFF, 8'hFF, 1'b1);
    check_idle_after("dFFFF_FF", 16'hFFFF, 8'hFF);
    do_div("d00FF_01", 16'h00FF, 8'h01, 1'b1);
    check_idle_after("d00FF_01", 16'h00FF, 8'h01);
    do_div("d5_200", 16'd5, 8'd200, 1'b1);
    check_idle_after("d5_200", 16'd5, 8'd200);
    do_div("dbz", 16'h1234, 8'd0, 1'b0);
    check_idle_after("dbz", 16'h1234, 8'd0);

    // Start pulsed mid-calculation is ignored
    bus_if.start = 1'b1; bus_if.dividend = 16'd1000; bus_if.divisor = 8'd7;
    tick();                                // E0
    bus_if.start = 1'b0;
    repeat (4) tick();                     // after E4
    bus_if.start = 1'b1; bus_if.dividend = 16'd50; bus_if.divisor = 8'd5;
    tick();                                // E5
    bus_if.start = 1'b0;
    lat = 5;
    while (!bus_if.done && lat < 40) begin
      tick();
      lat++;
    end
    chk("busy_start_latency", lat, 16);
    chk("busy_start_quot", bus_if.quotient, 142);
    chk("busy_start_rem", bus_if.remainder, 6);
    // Back-to-back: start presented in the DONE cycle
    do_div("b2b_50_5", 16'd50, 8'd5, 1'b1);
    extra_done = 0;
    repeat (20) begin
      tick();
      extra_done += int'(bus_if.done);
    end
    chk("no_queued_done", extra_done, 0);

    // Reset in the middle of a calculation
    bus_if.start = 1'b1; bus_if.dividend = 16'd1000; bus_if.divisor = 8'd7;
    tick();                                // E0
    bus_if.start = 1'b0;
    repeat (7) tick();                     // after E7
    rst = 1'b1;
    tick();                                // E8
    rst = 1'b0;
    chk("abort_busy", bus_if.busy, 0);
    chk("abort_done", bus_if.done, 0);
    chk("abort_quot", bus_if.quotient, 0);
    chk("abort_rem", bus_if.remainder, 0);
    chk("abort_dbz", bus_if.div_by_zero, 0);
    extra_done = 0;
    repeat (20) begin
      tick();
      extra_done += int'(bus_if.done);
    end
    chk("abort_no_done", extra_done, 0);
    do_div("d300_9", 16'd300, 8'd9, 1'b1);
    check_idle_after("d300_9", 16'd300, 8'd9);

    // Random regression, chained back-to-back where the coin says so
    for (int i = 0; i < 2000; i++) begin
      a = 16'($urandom);
      if ($urandom_range(0, 3) == 0) a = 16'($urandom_range(0, 4095));
      b = 8'($urandom_range(1, 255));
      if ($urandom_range(0, 49) == 0) b = 8'd0;
      do_div("rnd", a, b, 1'b1);
      if ($urandom_range(0, 1) == 0) check_idle_after("rnd", a, b);
    end
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
